// File: rtl/iagc_control_fsm_if.sv
// Handshake bundle between the IAGC sequencer and its neighbours: receiver,
// command_unit decode flags, sampler, sample memory and dump transmitter.
interface iagc_control_fsm_if #(
    parameter int IAGC_STATUS_SIZE = 4,
    parameter int DATA_SIZE        = 8,
    parameter int CMD_PARAM_SIZE   = 4,
    parameter int MEM_ADDR_SIZE    = 10
);
    logic [DATA_SIZE-1:0]        i_rx_data;
    logic                        i_rx_valid;
    logic                        i_cmd_reset;
    logic                        i_cmd_sample;
    logic                        i_cmd_set_decim;
    logic                        i_cmd_clean_mem;
    logic                        i_cmd_dump_mem;
    logic                        i_cmd_set_mem;
    logic [CMD_PARAM_SIZE-1:0]   i_cmd_param;
    logic                        i_mem_full;
    logic                        i_dump_ack;
    logic [IAGC_STATUS_SIZE-1:0] o_iagc_status;
    logic [DATA_SIZE-1:0]        o_cmd;
    logic                        o_sample_en;
    logic                        o_decim_load;
    logic [CMD_PARAM_SIZE-1:0]   o_decim_value;
    logic [CMD_PARAM_SIZE-1:0]   o_mem_sel;
    logic                        o_mem_we;
    logic [MEM_ADDR_SIZE-1:0]    o_mem_addr;
    logic                        o_dump_req;
    logic                        o_dump_last;
    logic                        o_cmd_error;
    logic                        o_rx_overrun;

    modport master (
        input  i_rx_data, i_rx_valid, i_cmd_reset, i_cmd_sample, i_cmd_set_decim,
               i_cmd_clean_mem, i_cmd_dump_mem, i_cmd_set_mem, i_cmd_param,
               i_mem_full, i_dump_ack,
        output o_iagc_status, o_cmd, o_sample_en, o_decim_load, o_decim_value,
               o_mem_sel, o_mem_we, o_mem_addr, o_dump_req, o_dump_last,
               o_cmd_error, o_rx_overrun
    );

    modport slave (
        output i_rx_data, i_rx_valid, i_cmd_reset, i_cmd_sample, i_cmd_set_decim,
               i_cmd_clean_mem, i_cmd_dump_mem, i_cmd_set_mem, i_cmd_param,
               i_mem_full, i_dump_ack,
        input  o_iagc_status, o_cmd, o_sample_en, o_decim_load, o_decim_value,
               o_mem_sel, o_mem_we, o_mem_addr, o_dump_req, o_dump_last,
               o_cmd_error, o_rx_overrun
    );
endinterface

// File: rtl/iagc_control_fsm.sv
// IAGC top-level sequencer: latches command bytes for command_unit, branches on
// its registered decode flags, and runs the memory clean sweep and dump handshake.
module iagc_control_fsm #(
    parameter int IAGC_STATUS_SIZE = 4,
    parameter int DATA_SIZE        = 8,
    parameter int CMD_PARAM_SIZE   = 4,
    parameter int INIT_CYCLES      = 16,
    parameter int MEM_ADDR_SIZE    = 10
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    iagc_control_fsm_if.master bus
);
    localparam logic [IAGC_STATUS_SIZE-1:0] S_RESET     = IAGC_STATUS_SIZE'(0);
    localparam logic [IAGC_STATUS_SIZE-1:0] S_INIT      = IAGC_STATUS_SIZE'(1);
    localparam logic [IAGC_STATUS_SIZE-1:0] S_IDLE      = IAGC_STATUS_SIZE'(2);
    localparam logic [IAGC_STATUS_SIZE-1:0] S_SAMPLE    = IAGC_STATUS_SIZE'(3);
    localparam logic [IAGC_STATUS_SIZE-1:0] S_CMD_PARSE = IAGC_STATUS_SIZE'(4);
    localparam logic [IAGC_STATUS_SIZE-1:0] S_CMD_READ  = IAGC_STATUS_SIZE'(5);
    localparam logic [IAGC_STATUS_SIZE-1:0] S_CMD_ERROR = IAGC_STATUS_SIZE'(6);
    localparam logic [IAGC_STATUS_SIZE-1:0] S_DUMP_MEM  = IAGC_STATUS_SIZE'(7);
    localparam logic [IAGC_STATUS_SIZE-1:0] S_CLEAN_MEM = IAGC_STATUS_SIZE'(8);

    localparam int                     CNT_W     = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]         CNT_LAST  = CNT_W'(INIT_CYCLES - 1);
    localparam logic [MEM_ADDR_SIZE-1:0] ADDR_LAST = '1;

    logic [IAGC_STATUS_SIZE-1:0] state;
    logic [CNT_W-1:0]            init_cnt;
    logic [DATA_SIZE-1:0]        cmd_q;
    logic [MEM_ADDR_SIZE-1:0]    addr_q;
    logic [CMD_PARAM_SIZE-1:0]   decim_q;
    logic [CMD_PARAM_SIZE-1:0]   mem_sel_q;
    logic                        decim_load_q;
    logic                        overrun_q;
    logic                        rx_accept;

    // Only IDLE and SAMPLE can take a new byte; anywhere else it is dropped.
    assign rx_accept = bus.i_rx_valid && (state == S_IDLE || state == S_SAMPLE);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state        <= S_RESET;
            init_cnt     <= '0;
            cmd_q        <= '0;
            addr_q       <= '0;
            decim_q      <= '0;
            mem_sel_q    <= '0;
            decim_load_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            decim_load_q <= 1'b0;
            overrun_q    <= bus.i_rx_valid && !rx_accept;
            case (state)
                S_RESET: begin
                    init_cnt <= '0;
                    addr_q   <= '0;
                    state    <= S_INIT;
                end
                S_INIT: begin
                    if (init_cnt == CNT_LAST) state <= S_IDLE;
                    else                      init_cnt <= init_cnt + 1'b1;
                end
                S_IDLE, S_SAMPLE: begin
                    // A new byte beats i_mem_full when both land together in SAMPLE.
                    if (rx_accept) begin
                        cmd_q <= bus.i_rx_data;
                        state <= S_CMD_PARSE;
                    end else if (state == S_SAMPLE && bus.i_mem_full) begin
                        state <= S_IDLE;
                    end
                end
                S_CMD_PARSE: state <= S_CMD_READ;
                S_CMD_READ: begin
                    if (bus.i_cmd_reset) begin
                        state <= S_RESET;
                    end else if (bus.i_cmd_sample) begin
                        state <= S_SAMPLE;
                    end else if (bus.i_cmd_set_decim) begin
                        decim_q      <= bus.i_cmd_param;
                        decim_load_q <= 1'b1;
                        state        <= S_IDLE;
                    end else if (bus.i_cmd_set_mem) begin
                        mem_sel_q <= bus.i_cmd_param;
                        state     <= S_IDLE;
                    end else if (bus.i_cmd_clean_mem) begin
                        addr_q <= '0;
                        state  <= S_CLEAN_MEM;
                    end else if (bus.i_cmd_dump_mem) begin
                        addr_q <= '0;
                        state  <= S_DUMP_MEM;
                    end else begin
                        state <= S_CMD_ERROR;
                    end
                end
                S_CLEAN_MEM: begin
                    if (addr_q == ADDR_LAST) begin
                        addr_q <= '0;
                        state  <= S_IDLE;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                    end
                end
                S_DUMP_MEM: begin
                    if (bus.i_dump_ack) begin
                        if (addr_q == ADDR_LAST) begin
                            addr_q <= '0;
                            state  <= S_IDLE;
                        end else begin
                            addr_q <= addr_q + 1'b1;
                        end
                    end
                end
                S_CMD_ERROR: state <= S_IDLE;
                default:     state <= S_RESET;
            endcase
        end
    end

    assign bus.o_iagc_status = state;
    assign bus.o_cmd         = cmd_q;
    assign bus.o_sample_en   = (state == S_SAMPLE);
    assign bus.o_decim_load  = decim_load_q;
    assign bus.o_decim_value = decim_q;
    assign bus.o_mem_sel     = mem_sel_q;
    assign bus.o_mem_we      = (state == S_CLEAN_MEM);
    assign bus.o_mem_addr    = addr_q;
    assign bus.o_dump_req    = (state == S_DUMP_MEM);
    assign bus.o_dump_last   = (state == S_DUMP_MEM) && (addr_q == ADDR_LAST);
    assign bus.o_cmd_error   = (state == S_CMD_ERROR);
    assign bus.o_rx_overrun  = overrun_q;
endmodule

// File: tb/tb_iagc_control_fsm.sv
// Randomized command stream against a transaction-level model of the IAGC
// sequencer; the bench also plays command_unit, decoding o_cmd into flags.
module tb_iagc_control_fsm;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    // Transaction-level expectations kept by the bench
    int   exp_decim   = 0;
    int   exp_mem_sel = 0;
    int   exp_cmd     = 0;
    bit   in_sample   = 0;
    int   n_heavy     = 0;

    iagc_control_fsm_if bus ();

    iagc_control_fsm dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // command_unit stand-in: opcode 0 reset, 1 sample, 2 set_decim, 3 clean,
    // 4 dump, 5 set_mem, anything else unknown.
    task automatic tick();
        logic [7:0] c;
        @(posedge clk);
        #1;
        c = bus.o_cmd;
        bus.i_cmd_reset     = (c[7:4] == 4'd0);
        bus.i_cmd_sample    = (c[7:4] == 4'd1);
        bus.i_cmd_set_decim = (c[7:4] == 4'd2);
        bus.i_cmd_clean_mem = (c[7:4] == 4'd3);
        bus.i_cmd_dump_mem  = (c[7:4] == 4'd4);
        bus.i_cmd_set_mem   = (c[7:4] == 4'd5);
        bus.i_cmd_param     = c[3:0];
    endtask

    // Called while status should be RESET: 1 cycle of 0, 16 of 1, then 2.
    task automatic expect_init();
        chk("init_rst", bus.o_iagc_status, 0);
        chk("init_addr", bus.o_mem_addr, 0);
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("init_cnt", bus.o_iagc_status, 1);
        end
        tick();
        chk("init_idle", bus.o_iagc_status, 2);
        in_sample = 0;
    endtask

    task automatic send_cmd(input logic [7:0] b, input bit ack_every3);
        bit ovr;
        int a, cyc, done, ack, n;
        if (in_sample) chk("pre_sample", bus.o_sample_en, 1);
        else           chk("pre_idle", bus.o_iagc_status, 2);
        bus.i_rx_data  = b;
        bus.i_rx_valid = 1'b1;
        // rx must win over a simultaneous mem_full while sampling
        bus.i_mem_full = in_sample && ($urandom_range(0, 1) == 1);
        tick();
        bus.i_rx_valid = 1'b0;
        bus.i_mem_full = 1'b0;
        exp_cmd = b;
        in_sample = 0;
        chk("parse", bus.o_iagc_status, 4);
        chk("cmd", bus.o_cmd, exp_cmd);
        ovr = ($urandom_range(0, 2) == 0);
        if (ovr) begin
            bus.i_rx_data  = ~b;
            bus.i_rx_valid = 1'b1;
        end
        tick();
        bus.i_rx_valid = 1'b0;
        chk("read", bus.o_iagc_status, 5);
        chk("overrun_parse", bus.o_rx_overrun, ovr);
        chk("cmd_hold", bus.o_cmd, exp_cmd);
        tick();
        case (b[7:4])
            4'd0: expect_init();
            4'd1: begin
                chk("sample", bus.o_iagc_status, 3);
                chk("sample_en", bus.o_sample_en, 1);
                n = $urandom_range(0, 4);
                for (int i = 0; i < n; i++) begin
                    tick();
                    chk("sample_stay", bus.o_sample_en, 1);
                end
                if ($urandom_range(0, 1) == 1) begin
                    bus.i_mem_full = 1'b1;
                    tick();
                    bus.i_mem_full = 1'b0;
                    chk("full_idle", bus.o_iagc_status, 2);
                    chk("full_en", bus.o_sample_en, 0);
                end else begin
                    in_sample = 1;
                end
            end
            4'd2: begin
                exp_decim = b[3:0];
                chk("decim_st", bus.o_iagc_status, 2);
                chk("decim_val", bus.o_decim_value, exp_decim);
                chk("decim_load", bus.o_decim_load, 1);
                tick();
                chk("decim_pulse", bus.o_decim_load, 0);
            end
            4'd5: begin
                exp_mem_sel = b[3:0];
                chk("memsel_st", bus.o_iagc_status, 2);
                chk("memsel_val", bus.o_mem_sel, exp_mem_sel);
            end
            4'd3: begin
                for (int i = 0; i < 1024; i++) begin
                    chk("clean_st", bus.o_iagc_status, 8);
                    chk("clean_we", bus.o_mem_we, 1);
                    chk("clean_addr", bus.o_mem_addr, i);
                    if (i == 3) begin
                        bus.i_rx_data  = 8'h55;
                        bus.i_rx_valid = 1'b1;
                        tick();
                        bus.i_rx_valid = 1'b0;
                        chk("overrun_clean", bus.o_rx_overrun, 1);
                    end else begin
                        tick();
                    end
                end
                chk("clean_done", bus.o_iagc_status, 2);
                chk("clean_addr0", bus.o_mem_addr, 0);
                chk("clean_we0", bus.o_mem_we, 0);
                chk("clean_cmd", bus.o_cmd, exp_cmd);
            end
            4'd4: begin
                a = 0; cyc = 0; done = 0;
                while (!done && cyc < 8000) begin
                    chk("dump_st", bus.o_iagc_status, 7);
                    chk("dump_req", bus.o_dump_req, 1);
                    chk("dump_addr", bus.o_mem_addr, a);
                    chk("dump_last", bus.o_dump_last, a == 1023);
                    ack = ack_every3 ? (cyc % 3 == 2) : ($urandom_range(0, 2) == 0);
                    bus.i_dump_ack = ack[0];
                    tick();
                    bus.i_dump_ack = 1'b0;
                    cyc++;
                    if (ack != 0) begin
                        if (a == 1023) done = 1;
                        else           a++;
                    end
                end
                if (!done) chk("dump_timeout", 0, 1);
                chk("dump_done", bus.o_iagc_status, 2);
                chk("dump_addr0", bus.o_mem_addr, 0);
                chk("dump_req0", bus.o_dump_req, 0);
            end
            default: begin
                chk("err_st", bus.o_iagc_status, 6);
                chk("err_pulse", bus.o_cmd_error, 1);
                tick();
                chk("err_idle", bus.o_iagc_status, 2);
                chk("err_pulse0", bus.o_cmd_error, 0);
            end
        endcase
        chk("decim_keep", bus.o_decim_value, exp_decim);
        chk("memsel_keep", bus.o_mem_sel, exp_mem_sel);
    endtask

    initial begin
        logic [7:0] b;
        bus.i_rx_data = '0;   bus.i_rx_valid = 1'b0;
        bus.i_cmd_reset = 1'b0; bus.i_cmd_sample = 1'b0; bus.i_cmd_set_decim = 1'b0;
        bus.i_cmd_clean_mem = 1'b0; bus.i_cmd_dump_mem = 1'b0; bus.i_cmd_set_mem = 1'b0;
        bus.i_cmd_param = '0; bus.i_mem_full = 1'b0; bus.i_dump_ack = 1'b0;
        tick(); tick();
        chk("rst_status", bus.o_iagc_status, 0);
        chk("rst_cmd", bus.o_cmd, 0);
        chk("rst_we", bus.o_mem_we, 0);
        chk("rst_req", bus.o_dump_req, 0);
        chk("rst_ovr", bus.o_rx_overrun, 0);
        rst_n = 1'b1;
        expect_init();

        send_cmd(8'h27, 0);
        send_cmd(8'h10, 0);
        if (in_sample) begin
            bus.i_mem_full = 1'b1;
            tick();
            bus.i_mem_full = 1'b0;
            chk("full_idle_d", bus.o_iagc_status, 2);
            in_sample = 0;
        end
        send_cmd(8'h5A, 0);
        send_cmd(8'h10, 0);
        if (!in_sample) send_cmd(8'h10, 0);
        send_cmd(8'h30, 0);
        send_cmd(8'h40, 1);
        send_cmd(8'hF0, 0);
        send_cmd(8'h03, 0);

        for (int k = 0; k < 40; k++) begin
            b = 8'($urandom);
            if (b[7:4] == 4'd3 || b[7:4] == 4'd4) begin
                if (n_heavy >= 3) b[7:4] = 4'd2;
                else              n_heavy++;
            end
            send_cmd(b, 0);
        end

        // Abort a dump with an asynchronous reset
        if (in_sample) begin
            bus.i_mem_full = 1'b1;
            tick();
            bus.i_mem_full = 1'b0;
            in_sample = 0;
        end
        bus.i_rx_data = 8'h40; bus.i_rx_valid = 1'b1;
        tick();
        bus.i_rx_valid = 1'b0;
        tick(); tick();
        bus.i_dump_ack = 1'b1; tick(); tick(); bus.i_dump_ack = 1'b0;
        chk("abort_pre", bus.o_iagc_status, 7);
        chk("abort_addr", bus.o_mem_addr, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_st", bus.o_iagc_status, 0);
        chk("abort_req", bus.o_dump_req, 0);
        chk("abort_addr0", bus.o_mem_addr, 0);
        chk("abort_cmd", bus.o_cmd, 0);
        chk("abort_decim", bus.o_decim_value, 0);
        chk("abort_memsel", bus.o_mem_sel, 0);
        exp_decim = 0; exp_mem_sel = 0;
        tick();
        rst_n = 1'b1;
        expect_init();
        send_cmd(8'h29, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
